// File: rtl/ctrl_api_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_api_pkg
//  Description : Shared control-header layout, FSM state and command record
//                types for the control message depacketizer.
//  Revision    : 1.0 - initial release
// ============================================================================
package ctrl_api_pkg;

    // Header beat layout (64-bit beat; bits [15:0] are reserved)
    localparam int OPCODE_MSB = 63;
    localparam int OPCODE_LSB = 56;
    localparam int FLAGS_MSB  = 55;
    localparam int FLAGS_LSB  = 48;
    localparam int SEQ_MSB    = 47;
    localparam int SEQ_LSB    = 32;
    localparam int LEN_MSB    = 31;
    localparam int LEN_LSB    = 16;

    localparam int DEFAULT_MAX_PAYLOAD_BEATS = 256;

    typedef enum logic [1:0] {
        HDR   = 2'd0,
        CMD   = 2'd1,
        PAY   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [7:0]  flags;
        logic [15:0] seq;
        logic [15:0] len;
        logic [15:0] src_port;
        logic [31:0] src_ip;
    } cmd_rec_t;

endpackage
`default_nettype wire

// File: rtl/control_msg_depacketizer_if.sv
`default_nettype none
// ============================================================================
//  Module      : control_msg_depacketizer_if
//  Description : Input stream, command record and payload stream bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
interface control_msg_depacketizer_if #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8,
    parameter int PORT_WIDTH = 16,
    parameter int IP_WIDTH   = 32
) ();
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic [KEEP_WIDTH-1:0] s_tkeep;
    logic [PORT_WIDTH-1:0] s_tid;
    logic [PORT_WIDTH-1:0] s_tdest;
    logic [IP_WIDTH-1:0]   s_tuser;
    logic                  s_tlast;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [7:0]            cmd_opcode;
    logic [7:0]            cmd_flags;
    logic [15:0]           cmd_seq;
    logic [15:0]           cmd_len;
    logic [PORT_WIDTH-1:0] cmd_src_port;
    logic [IP_WIDTH-1:0]   cmd_src_ip;

    logic                  pay_tvalid;
    logic                  pay_tready;
    logic [DATA_WIDTH-1:0] pay_tdata;
    logic [KEEP_WIDTH-1:0] pay_tkeep;
    logic                  pay_tlast;

    // Environment side: drives the input stream, consumes command and payload
    modport master (
        output s_tvalid, s_tdata, s_tkeep, s_tid, s_tdest, s_tuser, s_tlast,
        input  s_tready,
        input  cmd_valid, cmd_opcode, cmd_flags, cmd_seq, cmd_len, cmd_src_port, cmd_src_ip,
        output cmd_ready,
        input  pay_tvalid, pay_tdata, pay_tkeep, pay_tlast,
        output pay_tready
    );

    // Depacketizer side
    modport slave (
        input  s_tvalid, s_tdata, s_tkeep, s_tid, s_tdest, s_tuser, s_tlast,
        output s_tready,
        output cmd_valid, cmd_opcode, cmd_flags, cmd_seq, cmd_len, cmd_src_port, cmd_src_ip,
        input  cmd_ready,
        output pay_tvalid, pay_tdata, pay_tkeep, pay_tlast,
        input  pay_tready
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_axis_skid.sv
`default_nettype none
// ============================================================================
//  Module      : ctrl_axis_skid
//  Description : Two-entry registered skid buffer for data/keep/last with a
//                fully registered ready towards the source.
//  Revision    : 1.0 - initial release
// ============================================================================
module ctrl_axis_skid #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = 8
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst_n,
    input  wire logic                  i_valid,
    output logic                       o_ready,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    input  wire logic [KEEP_WIDTH-1:0] i_keep,
    input  wire logic                  i_last,
    output logic                       o_valid,
    input  wire logic                  i_ready,
    output logic [DATA_WIDTH-1:0]      o_data,
    output logic [KEEP_WIDTH-1:0]      o_keep,
    output logic                       o_last
);
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_WIDTH-1:0] r_out_keep;
    logic                  r_out_last;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [KEEP_WIDTH-1:0] r_skid_keep;
    logic                  r_skid_last;
    logic                  w_in_fire;

    assign o_ready   = !r_skid_valid;
    assign w_in_fire = i_valid && !r_skid_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
        end else if (!r_out_valid || i_ready) begin
            // Output stage free this cycle: refill from skid first to keep order
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= r_skid_data;
                r_out_keep   <= r_skid_keep;
                r_out_last   <= r_skid_last;
                r_skid_valid <= 1'b0;
            end else begin
                r_out_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_out_data <= i_data;
                    r_out_keep <= i_keep;
                    r_out_last <= i_last;
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_data  <= i_data;
            r_skid_keep  <= i_keep;
            r_skid_last  <= i_last;
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_keep  = r_out_keep;
    assign o_last  = r_out_last;

endmodule
`default_nettype wire

// File: rtl/control_msg_depacketizer.sv
`default_nettype none
// ============================================================================
//  Module      : control_msg_depacketizer
//  Description : Splits control packets into a command record plus a
//                length-checked payload stream; malformed packets are drained
//                and counted. Optional destination-port filter is enabled by
//                defining CTRL_DEPACK_PORT_FILTER_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_msg_depacketizer
    import ctrl_api_pkg::*;
#(
    parameter int                      AXIS_DATA_WIDTH   = 64,
    parameter int                      AXIS_KEEP_WIDTH   = 8,
    parameter int                      IP_PORT_WIDTH     = 16,
    parameter int                      IP_ADDRESS_WIDTH  = 32,
    parameter logic [IP_PORT_WIDTH-1:0] KIP_PORT_NUMBER  = 'hABCD,
    parameter int                      MAX_PAYLOAD_BEATS = DEFAULT_MAX_PAYLOAD_BEATS
) (
    input  wire logic                   i_clk,
    input  wire logic                   i_ap_rst_n,
    control_msg_depacketizer_if.slave   bus,
    output logic                        err_pulse,
    output logic [15:0]                 err_count
`ifdef CTRL_DEPACK_PORT_FILTER_EN
    ,
    output logic [15:0]                 filt_count
`endif
);
    localparam logic [15:0] c_max_len = 16'(MAX_PAYLOAD_BEATS);

    state_t      r_state;
    logic        r_alive;
    cmd_rec_t    r_cmd;
    logic        r_cmd_valid;
    logic [15:0] r_count;
    logic        r_err_pulse;
    logic [15:0] r_err_count;

    logic        w_s_tready;
    logic        w_skid_ready;
    logic        w_s_fire;
    logic        w_hdr_fire;
    logic        w_pay_fire;
    logic [15:0] w_len;
    logic        w_len_bad;
    logic        w_filt;
    logic        w_err;

    assign w_len = bus.s_tdata[LEN_MSB:LEN_LSB];

    // r_alive keeps s_tready low while reset is applied
    always_comb begin
        w_s_tready = 1'b0;
        case (r_state)
            HDR:     w_s_tready = r_alive;
            CMD:     w_s_tready = 1'b0;
            PAY:     w_s_tready = r_alive && w_skid_ready;
            DRAIN:   w_s_tready = r_alive;
            default: w_s_tready = 1'b0;
        endcase
    end

    assign w_s_fire   = bus.s_tvalid && w_s_tready;
    assign w_hdr_fire = (r_state == HDR) && w_s_fire;
    assign w_pay_fire = (r_state == PAY) && w_s_fire;

    assign w_len_bad = (w_len > c_max_len)
                    || ( bus.s_tlast && (w_len != 16'd0))
                    || (!bus.s_tlast && (w_len == 16'd0));

`ifdef CTRL_DEPACK_PORT_FILTER_EN
    assign w_filt = (bus.s_tdest != KIP_PORT_NUMBER);
`else
    logic w_unused_tdest;
    assign w_filt         = 1'b0;
    assign w_unused_tdest = ^{bus.s_tdest, KIP_PORT_NUMBER};
`endif

    // Payload error: packet ends exactly when the counter hits 1, otherwise bad
    assign w_err = (w_hdr_fire && !w_filt && w_len_bad)
                || (w_pay_fire && ((r_count == 16'd1) != bus.s_tlast));

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            r_state     <= HDR;
            r_alive     <= 1'b0;
            r_cmd       <= '0;
            r_cmd_valid <= 1'b0;
            r_count     <= 16'd0;
        end else begin
            r_alive <= 1'b1;
            case (r_state)
                HDR: begin
                    if (w_hdr_fire) begin
                        r_cmd <= '{opcode:   bus.s_tdata[OPCODE_MSB:OPCODE_LSB],
                                   flags:    bus.s_tdata[FLAGS_MSB:FLAGS_LSB],
                                   seq:      bus.s_tdata[SEQ_MSB:SEQ_LSB],
                                   len:      w_len,
                                   src_port: bus.s_tid,
                                   src_ip:   bus.s_tuser};
                        if (w_filt || w_len_bad) begin
                            r_state <= bus.s_tlast ? HDR : DRAIN;
                        end else begin
                            r_state     <= CMD;
                            r_cmd_valid <= 1'b1;
                        end
                    end
                end
                CMD: begin
                    if (r_cmd_valid && bus.cmd_ready) begin
                        r_cmd_valid <= 1'b0;
                        r_count     <= r_cmd.len;
                        r_state     <= (r_cmd.len == 16'd0) ? HDR : PAY;
                    end
                end
                PAY: begin
                    if (w_pay_fire) begin
                        r_count <= r_count - 16'd1;
                        if ((r_count == 16'd1) || bus.s_tlast) begin
                            r_state <= bus.s_tlast ? HDR : DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_s_fire && bus.s_tlast) begin
                        r_state <= HDR;
                    end
                end
                default: r_state <= HDR;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_count <= 16'd0;
        end else begin
            r_err_pulse <= w_err;
            if (w_err && (r_err_count != 16'hFFFF)) begin
                r_err_count <= r_err_count + 16'd1;
            end
        end
    end

`ifdef CTRL_DEPACK_PORT_FILTER_EN
    logic [15:0] r_filt_count;

    always_ff @(posedge i_clk or negedge i_ap_rst_n) begin
        if (!i_ap_rst_n) begin
            r_filt_count <= 16'd0;
        end else if (w_hdr_fire && w_filt && (r_filt_count != 16'hFFFF)) begin
            r_filt_count <= r_filt_count + 16'd1;
        end
    end

    assign filt_count = r_filt_count;
`endif

    // Truncated and over-long packets both close the forwarded stream with tlast
    ctrl_axis_skid #(
        .DATA_WIDTH (AXIS_DATA_WIDTH),
        .KEEP_WIDTH (AXIS_KEEP_WIDTH)
    ) u_pay_skid (
        .i_clk   (i_clk),
        .i_rst_n (i_ap_rst_n),
        .i_valid (bus.s_tvalid && (r_state == PAY)),
        .o_ready (w_skid_ready),
        .i_data  (bus.s_tdata),
        .i_keep  (bus.s_tkeep),
        .i_last  (bus.s_tlast || (r_count == 16'd1)),
        .o_valid (bus.pay_tvalid),
        .i_ready (bus.pay_tready),
        .o_data  (bus.pay_tdata),
        .o_keep  (bus.pay_tkeep),
        .o_last  (bus.pay_tlast)
    );

    assign bus.s_tready     = w_s_tready;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_opcode   = r_cmd.opcode;
    assign bus.cmd_flags    = r_cmd.flags;
    assign bus.cmd_seq      = r_cmd.seq;
    assign bus.cmd_len      = r_cmd.len;
    assign bus.cmd_src_port = r_cmd.src_port[IP_PORT_WIDTH-1:0];
    assign bus.cmd_src_ip   = r_cmd.src_ip[IP_ADDRESS_WIDTH-1:0];
    assign err_pulse        = r_err_pulse;
    assign err_count        = r_err_count;

endmodule
`default_nettype wire

// File: doc/control_msg_depacketizer.md
Name: control_msg_depacketizer

Overview:
- Sits directly downstream of control_gw_network_bridge.
- Consumes its to_ctrl AXI-Stream. Beat 0 of each packet is a control header; the remaining beats are payload.
- Splits each packet into one command record (opcode, sequence, source IP/port, length) plus a length-checked payload stream for the control API core.
- Malformed packets are discarded and counted.

Parameters:
- AXIS_DATA_WIDTH, 64, stream data width (header layout fixed for 64).
- AXIS_KEEP_WIDTH, 8, tkeep width.
- IP_PORT_WIDTH, 16, tid/tdest width.
- IP_ADDRESS_WIDTH, 32, tuser width.
- KIP_PORT_NUMBER, 'hABCD, accepted destination port (used only with the optional feature).
- MAX_PAYLOAD_BEATS, 256, largest legal header length field.

Ports:
- i_clk  in  1  clock.
- i_ap_rst_n  in  1  asynchronous active-low reset.
- s_tvalid  in  1  input stream valid (from to_ctrl).
- s_tready  out  1  input stream ready.
- s_tdata  in  64  input data.
- s_tkeep  in  8  input keep.
- s_tid  in  16  source port.
- s_tdest  in  16  destination port.
- s_tuser  in  32  source IP.
- s_tlast  in  1  end of packet.
- cmd_valid  out  1  command record valid.
- cmd_ready  in  1  command record ready.
- cmd_opcode  out  8  opcode.
- cmd_flags  out  8  flags.
- cmd_seq  out  16  sequence number.
- cmd_len  out  16  payload length in beats.
- cmd_src_port  out  16  tid captured at the header beat.
- cmd_src_ip  out  32  tuser captured at the header beat.
- pay_tvalid  out  1  payload valid.
- pay_tready  in  1  payload ready.
- pay_tdata  out  64  payload data.
- pay_tkeep  out  8  payload keep.
- pay_tlast  out  1  last payload beat.
- err_pulse  out  1  one-cycle pulse per discarded packet.
- err_count  out  16  saturating count of discarded packets.

Behaviour:
- Header beat layout:
  - [63:56] opcode
  - [55:48] flags
  - [47:32] seq
  - [31:16] len (payload beats)
  - [15:0] reserved, ignored
- Reset (asynchronous, i_ap_rst_n low): all outputs 0, state HDR, beat counter 0, err_count 0.
- State HDR:
  - s_tready=1.
  - On header handshake, register the cmd_* fields.
  - If len > MAX_PAYLOAD_BEATS, or (tlast=1 and len≠0), or (tlast=0 and len=0): error; go to DRAIN, or straight to HDR if tlast=1.
  - Otherwise go to CMD.
- State CMD:
  - s_tready=0; cmd_valid=1 one cycle after the header handshake.
  - On cmd handshake: if len=0 go to HDR, else go to PAY with counter=len.
  - cmd_* fields are stable while cmd_valid && !cmd_ready.
- State PAY:
  - Input beats pass through a registered skid slice.
  - s_tready follows the slice's ready; one-cycle latency from input to payload output; no bubbles at full throughput.
  - Counter decrements per accepted beat. pay_tlast=1 on the beat where counter==1.
  - If counter==1 and s_tlast=1: go to HDR.
  - If counter==1 and s_tlast=0 (too long): pay_tlast still asserted on that beat; raise error; go to DRAIN.
  - If s_tlast=1 with counter>1 (too short): forward the beat with pay_tlast=1 (truncated); raise error; go to HDR.
- State DRAIN:
  - s_tready=1; beats discarded, nothing forwarded.
  - Return to HDR on the s_tlast beat.
- Error accounting:
  - err_pulse is registered, asserted the cycle after the error is detected.
  - err_count increments once per erroneous packet and saturates at 'hFFFF.
- Reset mid-packet: the partial packet is lost. After reset the next beat is treated as a header, so upstream must be reset together with this block.
- No beat is ever accepted in CMD. A header for the next packet is not accepted until the current packet's final beat has been accepted.

Optional Feature:
- Macro: CTRL_DEPACK_PORT_FILTER_EN.
- Defined: in HDR, a header whose s_tdest ≠ KIP_PORT_NUMBER is dropped silently:
  - goes to DRAIN, or stays in HDR if tlast=1;
  - no cmd_valid, no err_pulse;
  - counted in an extra output port filt_count (16-bit, saturating).
- Undefined: tdest is ignored and the filt_count port does not exist.

Decomposition:
- Shared package ctrl_api_pkg holds:
  - header field offsets and widths (OPCODE_MSB/LSB, FLAGS, SEQ, LEN);
  - the state enum typedef {HDR, CMD, PAY, DRAIN};
  - the cmd record struct typedef;
  - MAX_PAYLOAD_BEATS default.
- One sub-module, ctrl_axis_skid: a 2-entry registered skid buffer for data/keep/last, used on the payload path.

Test Plan:
- Header 'h01_00_0005_0002_0000 from tid 'hAEAE, tuser 'hA0A0A0A0, then 2 payload beats 'hEFEF…EF (second with tlast), pay_tready=1 → cmd_opcode=1, seq=5, len=2, src_port 'hAEAE, src_ip 'hA0A0A0A0; two payload beats, last with pay_tlast; err_count 0.
- Header len=0 with tlast=1 → one command, no payload beats, back to HDR; a back-to-back next header is accepted.
- Header len=3, tlast on the 2nd payload beat → 2 beats forwarded, the 2nd with pay_tlast; err_pulse once; err_count=1.
- Header len=1 followed by 3 beats → 1 beat forwarded with pay_tlast; 2 beats drained; err_count increments once.
- cmd_ready held 0 for 5 cycles, then pay_tready toggled 1/0 each cycle → cmd fields stable; s_tready=0 during CMD; payload order and values preserved.
- With CTRL_DEPACK_PORT_FILTER_EN, tdest 'hAFAF → packet dropped, filt_count=1, err_count unchanged. Then reset asserted mid-payload → all outputs 0 and the next beat is parsed as a header.
